// File: rtl/bus_dec.sv
// Bus decoder / multiplexer with a slave-ack watchdog.
// Decodes the master word address against per-slave base/mask windows, routes
// the strobe to the lowest-index matching slave, muxes its read data and ack
// back, and terminates unmapped or hung accesses with a one-cycle error ack.
// The first failing address is captured for software; further errors while
// the capture is held only raise the overflow flag.
module bus_dec #(
    parameter int                  NSLV = 8,
    parameter int                  AW   = 22,
    parameter int                  TMO  = 255,
    parameter int                  CW   = 16,
    parameter logic [NSLV*AW-1:0]  BASE = '0,
    parameter logic [NSLV*AW-1:0]  MASK = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   m_stb,
    input  logic                   m_we,
    input  logic [AW-1:0]          m_addr,
    output logic [31:0]            m_din,
    output logic                   m_ack,
    output logic                   m_err,
    output logic [NSLV-1:0]        s_stb,
    input  logic [32*NSLV-1:0]     s_dout,
    input  logic [NSLV-1:0]        s_ack,
    input  logic                   err_clr,
    output logic                   err_valid,
    output logic [1:0]             err_code,
    output logic                   err_ovf,
    output logic [AW-1:0]          err_addr
);

    localparam int             SW         = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam logic [CW-1:0]  CNT_LAST   = CW'(TMO - 1);
    localparam logic [1:0]     CODE_UNMAP = 2'b01;
    localparam logic [1:0]     CODE_TMO   = 2'b10;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_ERRACK = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CW-1:0]     cnt_r;
    logic [CW-1:0]     cnt_nxt_s;
    logic [NSLV-1:0]   hit_vec_s;
    logic              hit_any_s;
    logic [SW-1:0]     sel_s;
    logic              err_take_s;
    logic [1:0]        err_cause_s;
    logic [NSLV-1:0]   s_stb_s;
    logic [31:0]       m_din_s;
    logic              m_ack_s;
    logic              m_err_s;
    logic              err_valid_r;
    logic [1:0]        err_code_r;
    logic              err_ovf_r;
    logic [AW-1:0]     err_addr_r;

    // Write enable travels to the slaves on their own bus wiring; it plays
    // no part in address decoding.
    logic              unused_s;
    assign unused_s = m_we;

    // Window match per slave, then pick the lowest matching index.
    always_comb begin
        hit_vec_s = '0;
        hit_any_s = 1'b0;
        sel_s     = '0;
        for (int i = 0; i < NSLV; i++) begin
            hit_vec_s[i] = ((m_addr & MASK[i*AW +: AW]) ==
                            (BASE[i*AW +: AW] & MASK[i*AW +: AW]));
        end
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (hit_vec_s[i]) begin
                hit_any_s = 1'b1;
                sel_s     = SW'(i);
            end else begin
                hit_any_s = hit_any_s;
            end
        end
    end

    // Next state, watchdog count and combinational bus responses.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        err_take_s  = 1'b0;
        err_cause_s = 2'b00;
        s_stb_s     = '0;
        m_din_s     = 32'h0000_0000;
        m_ack_s     = 1'b0;
        m_err_s     = 1'b0;
        if (!rst_n) begin
            // Hold every bus output low while reset is asserted.
            state_nxt_s = ST_RUN;
            cnt_nxt_s   = '0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (m_stb) begin
                        if (hit_any_s) begin
                            s_stb_s[sel_s] = 1'b1;
                            m_din_s        = s_dout[int'(sel_s)*32 +: 32];
                            m_ack_s        = s_ack[sel_s];
                            if (s_ack[sel_s]) begin
                                cnt_nxt_s = '0;
                            end else if (cnt_r == CNT_LAST) begin
                                // A slave ack in this final cycle still wins.
                                cnt_nxt_s   = '0;
                                state_nxt_s = ST_ERRACK;
                                err_take_s  = 1'b1;
                                err_cause_s = CODE_TMO;
                            end else begin
                                cnt_nxt_s = cnt_r + CW'(1);
                            end
                        end else begin
                            cnt_nxt_s   = '0;
                            state_nxt_s = ST_ERRACK;
                            err_take_s  = 1'b1;
                            err_cause_s = CODE_UNMAP;
                        end
                    end else begin
                        cnt_nxt_s = '0;
                    end
                end
                ST_ERRACK: begin
                    m_ack_s     = 1'b1;
                    m_err_s     = 1'b1;
                    cnt_nxt_s   = '0;
                    state_nxt_s = ST_RUN;
                end
                default: begin
                    cnt_nxt_s   = '0;
                    state_nxt_s = ST_RUN;
                end
            endcase
        end
    end

    // State and watchdog counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Sticky first-error capture; a new error beats a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid_r <= 1'b0;
            err_code_r  <= 2'b00;
            err_ovf_r   <= 1'b0;
            err_addr_r  <= '0;
        end else if (err_take_s) begin
            if (!err_valid_r || err_clr) begin
                err_valid_r <= 1'b1;
                err_code_r  <= err_cause_s;
                err_ovf_r   <= 1'b0;
                err_addr_r  <= m_addr;
            end else begin
                err_ovf_r   <= 1'b1;
            end
        end else if (err_clr) begin
            err_valid_r <= 1'b0;
            err_code_r  <= 2'b00;
            err_ovf_r   <= 1'b0;
        end else begin
            err_valid_r <= err_valid_r;
        end
    end

    assign s_stb     = s_stb_s;
    assign m_din     = m_din_s;
    assign m_ack     = m_ack_s;
    assign m_err     = m_err_s;
    assign err_valid = err_valid_r;
    assign err_code  = err_code_r;
    assign err_ovf   = err_ovf_r;
    assign err_addr  = err_addr_r;

endmodule

// File: tb/tb_bus_dec.sv
// Scoreboard bench for bus_dec: the driver pushes the expected master response
// (data, error flag, ack cycle) derived from window rules and the slave's ack
// delay; a monitor pops and compares whenever m_ack is seen.
module tb_bus_dec;

    localparam int NSLV = 4;
    localparam int AW   = 22;
    localparam int TMO  = 8;
    localparam int CW   = 4;
    localparam logic [NSLV*AW-1:0] BASE = {22'h200000, 22'h000000, 22'h3FF800, 22'h000000};
    localparam logic [NSLV*AW-1:0] MASK = {22'h300000, 22'h3F8000, 22'h3FFC00, 22'h3F0000};

    // Address windows as the bench sees them: slave 2 lies inside slave 0.
    logic [AW-1:0] ref_base [NSLV] = '{22'h000000, 22'h3FF800, 22'h000000, 22'h200000};
    logic [AW-1:0] ref_mask [NSLV] = '{22'h3F0000, 22'h3FFC00, 22'h3F8000, 22'h300000};

    logic                 clk;
    logic                 rst_n;
    logic                 m_stb;
    logic                 m_we;
    logic [AW-1:0]        m_addr;
    logic [31:0]          m_din;
    logic                 m_ack;
    logic                 m_err;
    logic [NSLV-1:0]      s_stb;
    logic [32*NSLV-1:0]   s_dout;
    logic [NSLV-1:0]      s_ack;
    logic                 err_clr;
    logic                 err_valid;
    logic [1:0]           err_code;
    logic                 err_ovf;
    logic [AW-1:0]        err_addr;

    bus_dec #(
        .NSLV(NSLV), .AW(AW), .TMO(TMO), .CW(CW), .BASE(BASE), .MASK(MASK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr),
        .m_din(m_din), .m_ack(m_ack), .m_err(m_err), .s_stb(s_stb),
        .s_dout(s_dout), .s_ack(s_ack), .err_clr(err_clr),
        .err_valid(err_valid), .err_code(err_code), .err_ovf(err_ovf),
        .err_addr(err_addr)
    );

    typedef struct {
        logic [31:0] din;
        logic        err;
        int          at;
    } exp_t;

    exp_t           sb [$];
    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;

    // Expected error-capture registers.
    logic           e_valid;
    logic [1:0]     e_code;
    logic           e_ovf;
    logic [AW-1:0]  e_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index used to check ack latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int ref_sel(input logic [AW-1:0] a);
        for (int i = 0; i < NSLV; i++) begin
            if ((a & ref_mask[i]) == (ref_base[i] & ref_mask[i])) return i;
        end
        return -1;
    endfunction

    function automatic void model_err(input logic [1:0] code, input logic [AW-1:0] a, input bit clr);
        if (!e_valid || clr) begin
            e_valid = 1'b1;
            e_code  = code;
            e_ovf   = 1'b0;
            e_addr  = a;
        end else begin
            e_ovf = 1'b1;
        end
    endfunction

    task automatic chk_err_regs();
        chk("err_valid", 64'(err_valid), 64'(e_valid));
        chk("err_code",  64'(err_code),  64'(e_code));
        chk("err_ovf",   64'(err_ovf),   64'(e_ovf));
        chk("err_addr",  64'(err_addr),  64'(e_addr));
    endtask

    // Monitor: every ack the DUT presents must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && m_ack) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack err=%0b din=%0h expected none (cycle %0d)", m_err, m_din, cyc);
            end else begin
                e = sb.pop_front();
                chk("ack_cycle", 64'(cyc),   64'(e.at));
                chk("m_din",     64'(m_din), 64'(e.din));
                chk("m_err",     64'(m_err), 64'(e.err));
            end
        end
    end

    // One master access; called at posedge+1. delay > TMO-1 means the slave
    // never acks; abandon > 0 drops the strobe after that many silent cycles.
    task automatic access(input logic [AW-1:0] a, input int delay, input bit clr_on_err,
                          input int abandon, input logic [31:0] dat);
        int  sel;
        int  c0;
        int  n;
        bit  is_err;
        bit  ab;
        logic [NSLV-1:0] es;
        sel    = ref_sel(a);
        c0     = cyc;
        ab     = (abandon > 0) && (sel >= 0);
        is_err = 1'b0;
        for (int i = 0; i < NSLV; i++) s_dout[32*i +: 32] = $urandom;
        if (sel >= 0) s_dout[32*sel +: 32] = dat;
        m_stb  = 1'b1;
        m_addr = a;
        m_we   = 1'($urandom);
        if (ab) begin
            n = abandon;
        end else if (sel < 0) begin
            n = 2;
            is_err = 1'b1;
            sb.push_back('{din: 32'h0, err: 1'b1, at: c0 + 1});
            model_err(2'b01, a, clr_on_err);
        end else if (delay <= TMO - 1) begin
            n = delay + 1;
            sb.push_back('{din: dat, err: 1'b0, at: c0 + delay});
        end else begin
            n = TMO + 1;
            is_err = 1'b1;
            sb.push_back('{din: 32'h0, err: 1'b1, at: c0 + TMO});
            model_err(2'b10, a, clr_on_err);
        end
        for (int k = 0; k < n; k++) begin
            s_ack = NSLV'($urandom);
            if (sel >= 0) s_ack[sel] = !ab && (k == delay) && (delay <= TMO - 1);
            err_clr = clr_on_err && is_err && (k == n - 2);
            es = '0;
            if (!(is_err && k == n - 1) && sel >= 0) es[sel] = 1'b1;
            #1;
            chk("s_stb", 64'(s_stb), 64'(es));
            @(posedge clk);
            #1;
            err_clr = 1'b0;
        end
        m_stb  = 1'b0;
        s_ack  = '0;
        m_addr = AW'($urandom);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk_err_regs();
    endtask

    task automatic idle(input int n, input bit clr);
        for (int k = 0; k < n; k++) begin
            m_stb   = 1'b0;
            s_ack   = NSLV'($urandom);
            err_clr = clr && (k == 0);
            @(posedge clk);
            #1;
            if (clr && k == 0) begin
                e_valid = 1'b0;
                e_code  = 2'b00;
                e_ovf   = 1'b0;
            end
            err_clr = 1'b0;
        end
        s_ack = '0;
    endtask

    initial begin
        logic [AW-1:0] a;
        int            kind;
        int            d;
        int            ab;
        rst_n   = 1'b0;
        m_stb   = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        s_dout  = '0;
        s_ack   = '0;
        err_clr = 1'b0;
        e_valid = 1'b0;
        e_code  = 2'b00;
        e_ovf   = 1'b0;
        e_addr  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_stb", 64'(s_stb), 64'd0);
        chk("rst_m_ack", 64'(m_ack), 64'd0);
        chk("rst_m_din", 64'(m_din), 64'd0);
        chk_err_regs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases.
        access(22'h3FF812, 3, 1'b0, 0, 32'hDEADBEEF);   // mapped read, slave 1
        access(22'h100000, 0, 1'b0, 0, 32'h0);          // unmapped
        idle(1, 1'b1);                                  // software clear
        access(22'h3FF900, 99, 1'b0, 0, 32'h0);         // timeout
        access(22'h3FF810, TMO - 1, 1'b0, 0, 32'h12345678); // ack on last cycle
        access(22'h000123, 2, 1'b0, 0, 32'hCAFEF00D);   // slaves 0 and 2 overlap
        access(22'h0F0000, 0, 1'b0, 0, 32'h0);          // second error -> overflow
        access(22'h155555, 0, 1'b1, 0, 32'h0);          // clear coincident with error
        access(22'h3FF804, 2, 1'b0, TMO - 2, 32'h0);    // strobe dropped mid-wait
        idle(1, 1'b0);
        access(22'h3FF804, TMO - 1, 1'b0, 0, 32'hA5A5A5A5); // count restarted at 0
        idle(1, 1'b0);

        // Randomized traffic.
        for (int t = 0; t < 200; t++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0:       a = AW'($urandom);
                1:       a = 22'h3FF800 | (AW'($urandom) & 22'h0003FF);
                2:       a = AW'($urandom) & 22'h00FFFF;
                default: a = 22'h200000 | (AW'($urandom) & 22'h0FFFFF);
            endcase
            d  = $urandom_range(0, TMO + 1);
            ab = 0;
            if ($urandom_range(0, 7) == 0) ab = $urandom_range(1, TMO - 1);
            access(a, d, $urandom_range(0, 3) == 0, ab, $urandom);
            if (ab > 0 || $urandom_range(0, 1) == 1) idle($urandom_range(1, 2), $urandom_range(0, 4) == 0);
        end

        // Reset in the middle of a wait.
        access(22'h100000, 0, 1'b0, 0, 32'h0);
        m_stb  = 1'b1;
        m_addr = 22'h3FF812;
        s_ack  = '0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        e_valid = 1'b0;
        e_code  = 2'b00;
        e_ovf   = 1'b0;
        e_addr  = '0;
        chk("rstmid_s_stb", 64'(s_stb), 64'd0);
        chk("rstmid_m_ack", 64'(m_ack), 64'd0);
        chk("rstmid_m_err", 64'(m_err), 64'd0);
        chk("rstmid_m_din", 64'(m_din), 64'd0);
        chk_err_regs();
        m_stb = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        access(22'h3FF812, TMO - 1, 1'b0, 0, 32'h0BADF00D);
        idle(2, 1'b0);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
